// File: rtl/dilated_tap_cache.sv
// -----------------------------------------------------------------------------
// dilated_tap_cache
//   Keeps the recent history of a sample stream in a ring buffer and presents a
//   set of four dilated taps for a downstream dot product:
//     a_d0 = x[t-3*DILATION], a_d1 = x[t-2*DILATION],
//     a_d2 = x[t-DILATION],   a_d3 = x[t]
//   The buffer has one write port and one read port, so the three historical
//   taps are gathered one per cycle (RD0, RD1, RD2) before the set is
//   presented. Taps that reach further back than the accepted history read 0
//   (causal zero padding), so the buffer memory itself never needs clearing.
//
// Ports
//   clk       sole clock, rising edge
//   rst_n     synchronous active-low reset
//   in_data   signed input sample x[t]
//   in_v      in_data valid (accepted when in_v && in_rdy)
//   in_rdy    ready for a new sample (idle state only)
//   a_d0..3   signed tap outputs, oldest to newest
//   taps_v    tap set valid
//   taps_rdy  downstream accepts the tap set (transfer on taps_v && taps_rdy)
// -----------------------------------------------------------------------------
module dilated_tap_cache #(
   parameter int W        = 16,
   parameter int DILATION = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] in_data,
   input  logic                in_v,
   output logic                in_rdy,
   output logic signed [W-1:0] a_d0,
   output logic signed [W-1:0] a_d1,
   output logic signed [W-1:0] a_d2,
   output logic signed [W-1:0] a_d3,
   output logic                taps_v,
   input  logic                taps_rdy
);

   localparam int N    = 3 * DILATION + 1;
   localparam int PW   = (N > 1) ? $clog2(N) : 1;
   localparam int FMAX = 3 * DILATION;
   localparam int FW   = $clog2(FMAX + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
   localparam logic [FW-1:0] FILL_MAX = FW'(FMAX);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD0     = 3'd1,
      S_RD1     = 3'd2,
      S_RD2     = 3'd3,
      S_PRESENT = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic                 accept_s;
   int                   rd_lag_s;
   logic [PW-1:0]        rd_idx_s;
   logic signed [W-1:0]  rd_val_s;

   logic signed [W-1:0]  mem_r [N];
   logic [PW-1:0]        wptr_r;
   logic [PW-1:0]        tpos_r;      // buffer slot holding x[t] of the set in flight
   logic [FW-1:0]        fill_r;      // accepted samples so far, saturating
   logic [FW-1:0]        fill_snap_r; // fill as seen by the set in flight
   logic signed [W-1:0]  a_d0_r;
   logic signed [W-1:0]  a_d1_r;
   logic signed [W-1:0]  a_d2_r;
   logic signed [W-1:0]  a_d3_r;
   logic                 taps_v_r;
   logic                 in_rdy_r;

   // Slot holding x[t-lag]; lag is always below N so a single wrap suffices.
   function automatic logic [PW-1:0] tap_idx(input logic [PW-1:0] pos, input int lag);
      int p;
      int r;
      p = int'(pos);
      if (p >= lag) begin
         r = p - lag;
      end else begin
         r = p + N - lag;
      end
      return r[PW-1:0];
   endfunction

   // A tap is real history only if at least 'lag' samples preceded x[t].
   function automatic logic tap_live(input logic [FW-1:0] fill, input int lag);
      return (int'(fill) >= lag);
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic, accept decode and per-state read lag.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      rd_lag_s = 0;
      case (state_r)
         S_IDLE: begin
            if (in_v && in_rdy_r) begin
               accept_s = 1'b1;
               state_s  = S_RD0;
            end else begin
               state_s  = S_IDLE;
            end
         end
         S_RD0: begin
            rd_lag_s = 3 * DILATION;
            state_s  = S_RD1;
         end
         S_RD1: begin
            rd_lag_s = 2 * DILATION;
            state_s  = S_RD2;
         end
         S_RD2: begin
            rd_lag_s = DILATION;
            state_s  = S_PRESENT;
         end
         S_PRESENT: begin
            if (taps_rdy) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_PRESENT;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Single read port: address and zero-padding mux for the tap being gathered.
   always_comb begin
      rd_idx_s = tap_idx(tpos_r, rd_lag_s);
      if (tap_live(fill_snap_r, rd_lag_s)) begin
         rd_val_s = mem_r[rd_idx_s];
      end else begin
         rd_val_s = {W{1'b0}};
      end
   end

   // History buffer write port; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (rst_n && accept_s) begin
         mem_r[wptr_r] <= in_data;
      end
   end

   // Pointer, fill tracking, tap capture and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_r      <= {PW{1'b0}};
         tpos_r      <= {PW{1'b0}};
         fill_r      <= {FW{1'b0}};
         fill_snap_r <= {FW{1'b0}};
         a_d0_r      <= {W{1'b0}};
         a_d1_r      <= {W{1'b0}};
         a_d2_r      <= {W{1'b0}};
         a_d3_r      <= {W{1'b0}};
         taps_v_r    <= 1'b0;
         in_rdy_r    <= 1'b0;
      end else begin
         in_rdy_r <= (state_s == S_IDLE);
         taps_v_r <= (state_s == S_PRESENT);
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  a_d3_r      <= in_data;
                  tpos_r      <= wptr_r;
                  fill_snap_r <= fill_r;
                  if (wptr_r == PTR_LAST) begin
                     wptr_r <= {PW{1'b0}};
                  end else begin
                     wptr_r <= wptr_r + {{(PW-1){1'b0}}, 1'b1};
                  end
                  if (fill_r != FILL_MAX) begin
                     fill_r <= fill_r + {{(FW-1){1'b0}}, 1'b1};
                  end else begin
                     fill_r <= fill_r;
                  end
               end else begin
                  a_d3_r <= a_d3_r;
               end
            end
            S_RD0:   a_d0_r <= rd_val_s;
            S_RD1:   a_d1_r <= rd_val_s;
            S_RD2:   a_d2_r <= rd_val_s;
            default: a_d0_r <= a_d0_r;
         endcase
      end
   end

   assign in_rdy = in_rdy_r;
   assign taps_v = taps_v_r;
   assign a_d0   = a_d0_r;
   assign a_d1   = a_d1_r;
   assign a_d2   = a_d2_r;
   assign a_d3   = a_d3_r;

endmodule

// File: doc/dilated_tap_cache.md
DILATED_TAP_CACHE -- requirements
Module: dilated_tap_cache

Interface
REQ-001 Parameter W, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter DILATION, default 4, tap spacing in samples; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on rising edge of clk.
REQ-005 in_data  input  W  signed input sample x[t].
REQ-006 in_v  input  1  in_data valid; sample accepted on a cycle with in_v=1 and in_rdy=1.
REQ-007 in_rdy  output  1  block ready to accept a sample.
REQ-008 a_d0  output  W  signed tap x[t-3*DILATION] (oldest).
REQ-009 a_d1  output  W  signed tap x[t-2*DILATION].
REQ-010 a_d2  output  W  signed tap x[t-DILATION].
REQ-011 a_d3  output  W  signed tap x[t] (current sample).
REQ-012 taps_v  output  1  a_d0..a_d3 form a valid tap set.
REQ-013 taps_rdy  input  1  downstream dot product accepts the tap set; transfer on taps_v=1 and taps_rdy=1.

Function
REQ-014 History SHALL be held in a ring buffer of N = 3*DILATION+1 entries of W bits, one write pointer wptr wrapping N-1 -> 0.
REQ-015 The buffer SHALL have one write and one read access per cycle; taps are gathered sequentially.
REQ-016 States: IDLE, RD0, RD1, RD2, PRESENT; in_rdy SHALL be 1 exactly in IDLE.
REQ-017 IDLE: on accept, write in_data to mem[wptr], latch in_data into a_d3 register, advance wptr, go RD0; else remain.
REQ-018 RD0: capture a_d0 from entry (t-3*DILATION) mod N; RD1: a_d1 from (t-2*DILATION) mod N; RD2: a_d2 from (t-DILATION) mod N; each state advances one cycle unconditionally.
REQ-019 RD2 SHALL transition to PRESENT with taps_v=1 on the next cycle; taps_v asserted exactly 4 cycles after the accept cycle.
REQ-020 PRESENT: hold a_d0..a_d3 and taps_v=1 stable until taps_rdy=1; on transfer, drop taps_v and return to IDLE next cycle.
REQ-021 Back-to-back throughput SHALL be one sample per 5 cycles with taps_rdy held 1.
REQ-022 in_v while in_rdy=0 SHALL be ignored (no write, no pointer or count change).
REQ-023 A fill counter SHALL count accepted samples before the current one, saturating at 3*DILATION.
REQ-024 Causal zero padding: a tap with lag L SHALL read 0 when fill < L, regardless of buffer contents; buffer memory is never cleared.
REQ-025 Index arithmetic SHALL be modulo N with no out-of-range access; (t-3*DILATION) mod N never equals the entry written at t.
REQ-026 Tap values SHALL be copied bit-exact, no rounding, scaling or sign change.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, wptr=0, fill=0, taps_v=0, a_d0..a_d3=0.
REQ-028 in_rdy SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-029 Reset in any state SHALL abandon the in-flight tap set; first sample after release sees all-zero history.

Verification
REQ-030 DILATION=2, taps_rdy=1, feed 1..7: outputs (0,0,0,1),(0,0,0,2),(0,0,1,3),(0,0,2,4),(0,1,3,5),(0,2,4,6),(1,3,5,7).
REQ-031 DILATION=1, feed -5,-6,-7,-8,-9: last set (-6,-7,-8,-9), sign preserved; taps_v exactly 4 cycles after each accept.
REQ-032 Hold taps_rdy=0 for 10 cycles in PRESENT with in_v=1: taps stable, taps_v=1, in_rdy=0, no sample written.
REQ-033 DILATION=4, feed 40 samples x[t]=t+1: wrap exercised; sample t=39 gives (28,32,36,40).
REQ-034 Assert rst_n=0 during RD1 after 20 samples, then feed 100: no taps_v for aborted set; next output (0,0,0,100).
